// File: rtl/aes_key_expand_if.sv
// Key-schedule port bundle between the control FSM (master) and the
// AES-128 key expansion unit (slave).
interface aes_key_expand_if;
    logic         key_load;
    logic [127:0] key_in;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         busy;
    logic         ready;

    modport master (
        output key_load, key_in, round_idx,
        input  round_key, busy, ready
    );

    modport slave (
        input  key_load, key_in, round_idx,
        output round_key, busy, ready
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands the cipher key one word per cycle into a
// 44-word register file and serves the selected round key combinationally.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 by repeated squaring; 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] b;

    always_comb begin
        b = gf_inv(a);
        s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             reset,
    aes_key_expand_if.slave  kx
);
    localparam int NW = NK * (NR + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    state_t       state_next;
    logic [31:0]  w [NW];
    logic [5:0]   cnt;
    logic [31:0]  prev;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  temp;
    logic [31:0]  new_word;
    logic [7:0]   rcon;
    logic [5:0]   base;
    logic         busy;
    logic         ready;
    logic [127:0] round_key;

    assign prev = w[cnt - 6'd1];
    assign rot  = {prev[23:0], prev[31:24]};

    aes_sbox u_sbox0 (.a(rot[31:24]), .s(sub[31:24]));
    aes_sbox u_sbox1 (.a(rot[23:16]), .s(sub[23:16]));
    aes_sbox u_sbox2 (.a(rot[15:8]),  .s(sub[15:8]));
    aes_sbox u_sbox3 (.a(rot[7:0]),   .s(sub[7:0]));

    always_comb begin
        rcon = 8'h00;
        case (cnt[5:2])
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Words at the start of each round get RotWord/SubWord/Rcon mixed in.
    always_comb begin
        temp = prev;
        if (cnt[1:0] == 2'b00) temp = sub ^ {rcon, 24'h000000};
        new_word = w[cnt - 6'd4] ^ temp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (kx.key_load) state_next = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (kx.key_load)                 state_next = EXPAND;
                else if (cnt == 6'(NW - 1))      state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                if (kx.key_load) state_next = EXPAND;
            end
            default: state_next = IDLE;
        endcase
    end

    // A load always wins, so a reload mid-expansion restarts cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) w[i] <= '0;
            cnt <= 6'd4;
        end else if (kx.key_load) begin
            w[0] <= kx.key_in[127:96];
            w[1] <= kx.key_in[95:64];
            w[2] <= kx.key_in[63:32];
            w[3] <= kx.key_in[31:0];
            cnt  <= 6'd4;
        end else if (state == EXPAND) begin
            w[cnt] <= new_word;
            cnt    <= cnt + 6'd1;
        end
    end

    assign base = {kx.round_idx, 2'b00};

    always_comb begin
        round_key = '0;
        if (kx.round_idx <= 4'(NR))
            round_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end

    assign kx.round_key = round_key;
    assign kx.busy      = busy;
    assign kx.ready     = ready;
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors, reload/abort, reset
// mid-expansion, round_idx sweep and a full AES-128 encryption.
module tb_aes_key_expand;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [7:0]   sbox_tb [256];
    logic [31:0]  wm [44];
    logic [127:0] st;
    int           n;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] PT       = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT       = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_key_expand_if kif ();

    aes_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .kx    (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_tb(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ m;
            m = xt(m);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox_tb[s[8*i +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] key);
        @(negedge clk);
        kif.key_load = 1'b1;
        kif.key_in   = key;
        @(negedge clk);
        kif.key_load = 1'b0;
    endtask

    // Counts negedges with busy high; bounded so a stuck DUT still ends.
    task automatic waitReady(output int cycles);
        cycles = 0;
        while (kif.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic readRound(input int r, output logic [127:0] k);
        kif.round_idx = 4'(r);
        #1;
        k = kif.round_key;
    endtask

    initial begin
        logic [7:0]   inv;
        logic [7:0]   b;
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [127:0] k;

        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        kif.key_load  = 1'b0;
        kif.key_in    = '0;
        kif.round_idx = 4'd0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul_tb(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_tb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        wm[0] = FIPS_KEY[127:96];
        wm[1] = FIPS_KEY[95:64];
        wm[2] = FIPS_KEY[63:32];
        wm[3] = FIPS_KEY[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = wm[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]], sbox_tb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wm[i] = wm[i-4] ^ t;
        end

        #12;
        checkOutput("reset_busy",  128'(kif.busy),  128'd0);
        checkOutput("reset_ready", 128'(kif.ready), 128'd0);
        readRound(0, k);
        checkOutput("reset_rk0", k, 128'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(FIPS_KEY);
        checkOutput("fips_busy_rise", 128'(kif.busy), 128'd1);
        waitReady(n);
        checkOutput("fips_busy_cycles", 128'(n), 128'd40);
        checkOutput("fips_ready", 128'(kif.ready), 128'd1);
        readRound(0, k);
        checkOutput("fips_r0", k, FIPS_KEY);
        readRound(1, k);
        checkOutput("fips_r1", k, FIPS_R1);
        readRound(10, k);
        checkOutput("fips_r10", k, FIPS_R10);

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            readRound(r, k);
            if (r <= 10) checkOutput($sformatf("sweep_r%0d", r), k, {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]});
            else         checkOutput($sformatf("sweep_r%0d", r), k, 128'd0);
        end

        // Control-FSM style encryption: one round per cycle, round key read live.
        st = PT;
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            readRound(r, k);
            if (r > 0) begin
                st = shift_rows(sub_bytes(st));
                if (r < 10) st = mix_columns(st);
            end
            st = st ^ k;
        end
        checkOutput("encrypt_ct", st, CT);

        applyStimulus(128'd0);
        waitReady(n);
        checkOutput("zero_busy_cycles", 128'(n), 128'd40);
        readRound(1, k);
        checkOutput("zero_r1", k, ZERO_R1);
        readRound(10, k);
        checkOutput("zero_r10", k, ZERO_R10);

        applyStimulus(FIPS_KEY);
        repeat (19) @(negedge clk);
        checkOutput("abort_busy_mid", 128'(kif.busy), 128'd1);
        applyStimulus(128'd0);
        waitReady(n);
        checkOutput("abort_busy_cycles", 128'(n), 128'd40);
        checkOutput("abort_ready", 128'(kif.ready), 128'd1);
        readRound(10, k);
        checkOutput("abort_r10", k, ZERO_R10);
        readRound(1, k);
        checkOutput("abort_r1", k, ZERO_R1);

        applyStimulus(FIPS_KEY);
        repeat (14) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy",  128'(kif.busy),  128'd0);
        checkOutput("midrst_ready", 128'(kif.ready), 128'd0);
        for (int r = 0; r < 16; r++) begin
            readRound(r, k);
            checkOutput($sformatf("midrst_r%0d", r), k, 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(FIPS_KEY);
        waitReady(n);
        checkOutput("reload_busy_cycles", 128'(n), 128'd40);
        checkOutput("reload_ready", 128'(kif.ready), 128'd1);
        readRound(10, k);
        checkOutput("reload_r10", k, FIPS_R10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
